// File: rtl/endpoint_flit_tx.sv
// ---------------------------------------------------------------------------
// endpoint_flit_tx
//
// Endpoint-side flit transmitter feeding a switch's local input port. Flits
// from the local source are staged in a small circular FIFO. One output
// register presents the head flit to the switch, and the switch's
// packet_sent acknowledge retires it. Flow control is credit based: one
// counter per virtual channel mirrors the free space in the switch's input
// buffer for that VC.
//
// Ports:
//   clk            system clock
//   n_rst          asynchronous active-low reset
//   in_valid       local source has a flit on in_flit
//   in_flit        local flit; its VC is in_flit.metadata.vc
//   in_ready       staging FIFO not full (push = in_valid & in_ready)
//   out            flit presented to the switch
//   data_ready_out out is valid
//   packet_sent    switch accepted out this cycle (ignored when idle)
//   credit_granted per-VC credit-return pulses
//   credit_count   packed per-VC credit counters, VC0 in the LSBs
//   fifo_count     staging FIFO occupancy
//   credit_err     sticky: a credit came back to a VC that was already full
// ---------------------------------------------------------------------------

package endpoint_flit_pkg;

  localparam int FLIT_NUM_VCS = 2;
  localparam int VC_W         = (FLIT_NUM_VCS > 1) ? $clog2(FLIT_NUM_VCS) : 1;

  typedef struct packed {
    logic [VC_W-1:0] vc;
    logic [3:0]      dest;
  } metadata_t;

  typedef struct packed {
    metadata_t   metadata;
    logic [31:0] payload;
  } flit_t;

endpackage

module endpoint_flit_tx
  import endpoint_flit_pkg::*;
#(
  parameter int NUM_VCS     = endpoint_flit_pkg::FLIT_NUM_VCS,
  parameter int BUFFER_SIZE = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                     clk,
  input  logic                                     n_rst,
  input  logic                                     in_valid,
  input  flit_t                                    in_flit,
  output logic                                     in_ready,
  output flit_t                                    out,
  output logic                                     data_ready_out,
  input  logic                                     packet_sent,
  input  logic [NUM_VCS-1:0]                       credit_granted,
  output logic [NUM_VCS*$clog2(BUFFER_SIZE+1)-1:0] credit_count,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]          fifo_count,
  output logic                                     credit_err
);

  localparam int CW  = $clog2(BUFFER_SIZE + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0]  CREDIT_MAX = CW'(BUFFER_SIZE);
  localparam logic [CW-1:0]  CREDIT_ONE = CW'(1);
  localparam logic [FCW-1:0] COUNT_ONE  = FCW'(1);
  localparam logic [AW:0]    PTR_ONE    = (AW + 1)'(1);

  typedef enum logic {
    OREG_EMPTY,
    OREG_HOLD
  } oreg_state_t;

  // Staging FIFO
  flit_t           mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [FCW-1:0]  count_q;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            pop;
  flit_t           head;

  // Credit tracking
  logic [CW-1:0]      credit_q [NUM_VCS];
  logic [CW-1:0]      credit_d [NUM_VCS];
  logic [NUM_VCS-1:0] head_sel;
  logic [NUM_VCS-1:0] consume;
  logic [NUM_VCS-1:0] overflow;
  logic               head_has_credit;
  logic               credit_err_q;

  // Output register
  oreg_state_t state_q;
  oreg_state_t state_d;
  flit_t       out_q;
  logic        load;

  // Full/empty come from the extra pointer bit: equal indices with differing
  // wrap bits means full, identical pointers means empty.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;
  assign pop        = load;
  assign head       = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= in_flit;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + COUNT_ONE;
        2'b01:   count_q <= count_q - COUNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  assign fifo_count = count_q;

  // Only the registered credit of the head's VC gates a load, so a credit
  // returned this cycle cannot be spent until the next one. A head whose VC
  // has no credit stalls everything behind it; there is no reordering.
  always_comb begin
    head_sel        = '0;
    head_has_credit = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (head.metadata.vc == VC_W'(v)) begin
        head_sel[v]     = 1'b1;
        head_has_credit = (credit_q[v] != '0);
      end
    end
  end

  assign load    = !fifo_empty && head_has_credit &&
                   ((state_q == OREG_EMPTY) || packet_sent);
  assign consume = head_sel & {NUM_VCS{load}};

  // The credit is reserved when the flit is loaded, not when the switch
  // accepts it. A return and a consume on the same VC cancel out. A lone
  // return to a full counter saturates and flags an error.
  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      credit_d[v] = credit_q[v];
      overflow[v] = 1'b0;
      case ({credit_granted[v], consume[v]})
        2'b10: begin
          if (credit_q[v] == CREDIT_MAX) begin
            overflow[v] = 1'b1;
          end else begin
            credit_d[v] = credit_q[v] + CREDIT_ONE;
          end
        end
        2'b01:   credit_d[v] = credit_q[v] - CREDIT_ONE;
        default: credit_d[v] = credit_q[v];
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        credit_q[v] <= CREDIT_MAX;
      end
      credit_err_q <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        credit_q[v] <= credit_d[v];
      end
      if (|overflow) begin
        credit_err_q <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_VCS; g++) begin : g_credit_pack
    assign credit_count[g*CW +: CW] = credit_q[g];
  end

  assign credit_err = credit_err_q;

  // Output register state. out_q only changes on load, so it keeps its last
  // value after the switch takes it and is stable while held.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= OREG_EMPTY;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        out_q <= head;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    data_ready_out = 1'b0;
    case (state_q)
      OREG_EMPTY: begin
        if (load) begin
          state_d = OREG_HOLD;
        end
      end
      OREG_HOLD: begin
        data_ready_out = 1'b1;
        if (packet_sent && !load) begin
          state_d = OREG_EMPTY;
        end
      end
      default: state_d = OREG_EMPTY;
    endcase
  end

  assign out = out_q;

endmodule
